// File: rtl/card_hand_dealer.sv
// Baccarat card dealer: a free-running 1..CARD_MAX shoe counter feeds three
// hand slots, one card per accepted request, followed by a hand re-score.
// The IDLE -> LOAD -> SCORE sequence gives the score one cycle to settle
// after the card lands, then acknowledges the deal.
module card_hand_dealer #(
    parameter int CARD_MAX = 13,
    parameter int FACE_MIN = 10
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       deal_req_i,
    input  logic       clear_i,
    output logic       deal_ack_o,
    output logic       deal_nack_o,
    output logic [3:0] card0_o,
    output logic [3:0] card1_o,
    output logic [3:0] card2_o,
    output logic [1:0] num_cards_o,
    output logic       hand_full_o,
    output logic [3:0] score_o
);

    localparam logic [3:0] CARD_MAX_C = 4'(CARD_MAX);
    localparam logic [3:0] FACE_MIN_C = 4'(FACE_MIN);

    typedef enum logic [1:0] {IDLE, LOAD, SCORE} state_e;

    state_e            state_q, state_d;
    logic [3:0]        shoe_q, shoe_d;
    logic [2:0][3:0]   slot_q, slot_d;
    logic [1:0]        num_q, num_d;
    logic [3:0]        score_q, score_d;
    logic              ack_q, ack_d;
    logic              nack_q, nack_d;
    logic [4:0]        sum;
    logic [3:0]        sum_mod;
    logic              full;

    // Face cards and tens are worth nothing; an empty slot (code 0) falls
    // through as 0 points naturally.
    function automatic logic [3:0] pts(input logic [3:0] code);
        return (code >= FACE_MIN_C) ? 4'd0 : code;
    endfunction

    assign full   = (num_q == 2'd3);
    assign shoe_d = (shoe_q >= CARD_MAX_C) ? 4'd1 : shoe_q + 4'd1;

    // Hand total (max 27) reduced mod 10 by a single subtract of 20 or 10.
    always_comb begin
        sum = {1'b0, pts(slot_q[0])} + {1'b0, pts(slot_q[1])} + {1'b0, pts(slot_q[2])};
        if (sum >= 5'd20)
            sum_mod = 4'(sum - 5'd20);
        else if (sum >= 5'd10)
            sum_mod = 4'(sum - 5'd10);
        else
            sum_mod = sum[3:0];
    end

    // Next-state and registered-output logic; clear wins over everything.
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        num_d   = num_q;
        score_d = score_q;
        ack_d   = 1'b0;
        nack_d  = 1'b0;
        if (clear_i) begin
            state_d = IDLE;
            slot_d  = '0;
            num_d   = 2'd0;
            score_d = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (deal_req_i) begin
                        if (full) begin
                            nack_d = 1'b1;
                        end else begin
                            case (num_q)
                                2'd0:    slot_d[0] = shoe_q;
                                2'd1:    slot_d[1] = shoe_q;
                                default: slot_d[2] = shoe_q;
                            endcase
                            num_d   = num_q + 2'd1;
                            state_d = LOAD;
                        end
                    end
                end
                LOAD: begin
                    score_d = sum_mod;
                    state_d = SCORE;
                end
                SCORE: begin
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register; the shoe keeps counting regardless of FSM state or clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            shoe_q  <= 4'd1;
            slot_q  <= '0;
            num_q   <= 2'd0;
            score_q <= 4'd0;
            ack_q   <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shoe_q  <= shoe_d;
            slot_q  <= slot_d;
            num_q   <= num_d;
            score_q <= score_d;
            ack_q   <= ack_d;
            nack_q  <= nack_d;
        end
    end

    assign card0_o     = slot_q[0];
    assign card1_o     = slot_q[1];
    assign card2_o     = slot_q[2];
    assign num_cards_o = num_q;
    assign hand_full_o = full;
    assign score_o     = score_q;
    assign deal_ack_o  = ack_q;
    assign deal_nack_o = nack_q;

endmodule

// File: tb/tb_card_hand_dealer.sv
// Bench for card_hand_dealer: a directed per-cycle vector table covering the
// deal/score/ack timing, shoe wrap, full hand and clear races, then mid-cycle
// resets and a randomized run against a queue-based hand model.
module tb_card_hand_dealer;

    localparam int CARD_MAX = 13;
    localparam int FACE_MIN = 10;

    logic       clk, rst, req, clr;
    logic       ack, nack, full;
    logic [3:0] c0, c1, c2, score;
    logic [1:0] num;

    card_hand_dealer #(.CARD_MAX(CARD_MAX), .FACE_MIN(FACE_MIN)) dut (
        .clk_i(clk), .rst_i(rst), .deal_req_i(req), .clear_i(clr),
        .deal_ack_o(ack), .deal_nack_o(nack),
        .card0_o(c0), .card1_o(c1), .card2_o(c2),
        .num_cards_o(num), .hand_full_o(full), .score_o(score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       req, clr;
        logic [3:0] c0, c1, c2;
        logic [1:0] num;
        logic [3:0] sc;
        logic       ack, nack;
    } vec_t;
    vec_t tbl[$];

    function automatic void v(input logic r, input logic c, input int a0, input int a1,
                              input int a2, input int n, input int s,
                              input logic ak, input logic nk);
        vec_t e;
        e.req = r; e.clr = c;
        e.c0 = 4'(a0); e.c1 = 4'(a1); e.c2 = 4'(a2);
        e.num = 2'(n); e.sc = 4'(s); e.ack = ak; e.nack = nk;
        tbl.push_back(e);
    endfunction

    function automatic void idle(input int cnt, input int a0, input int a1, input int a2,
                                 input int n, input int s);
        for (int i = 0; i < cnt; i++) v(1'b0, 1'b0, a0, a1, a2, n, s, 1'b0, 1'b0);
    endfunction

    function automatic logic [20:0] pack(input logic [3:0] a0, input logic [3:0] a1,
                                         input logic [3:0] a2, input logic [1:0] n,
                                         input logic [3:0] s, input logic ak, input logic nk);
        return {a0, a1, a2, n, (n == 2'd3), s, ak, nk};
    endfunction

    function automatic logic [20:0] dut_vec();
        return {c0, c1, c2, num, full, score, ack, nack};
    endfunction

    task automatic check(input string name, input logic [20:0] got, input logic [20:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got c0c1c2=%h%h%h num=%0d full=%b sc=%0d ack=%b nack=%b exp c0c1c2=%h%h%h num=%0d full=%b sc=%0d ack=%b nack=%b",
                     name, got[20:17], got[16:13], got[12:9], got[8:7], got[6], got[5:2], got[1], got[0],
                     exp[20:17], exp[16:13], exp[12:9], exp[8:7], exp[6], exp[5:2], exp[1], exp[0]);
        end
    endtask

    // Reference model: the hand is a queue of card codes; a deal is busy for two
    // more edges (score, then ack). The shoe is derived from edges since reset.
    int m_hand[$];
    int m_edges, m_busy, m_score;
    logic m_ack, m_nack;

    function automatic void model_reset();
        m_hand.delete();
        m_edges = 0; m_busy = 0; m_score = 0; m_ack = 1'b0; m_nack = 1'b0;
    endfunction

    function automatic void model_step(input logic r, input logic c);
        int shoe, s;
        shoe = (m_edges % CARD_MAX) + 1;
        m_edges++;
        m_ack = 1'b0; m_nack = 1'b0;
        if (c) begin
            m_hand.delete(); m_score = 0; m_busy = 0;
        end else if (m_busy == 2) begin
            s = 0;
            foreach (m_hand[i]) s += (m_hand[i] >= FACE_MIN) ? 0 : m_hand[i];
            m_score = s % 10;
            m_busy = 1;
        end else if (m_busy == 1) begin
            m_ack = 1'b1; m_busy = 0;
        end else if (r) begin
            if (m_hand.size() == 3) m_nack = 1'b1;
            else begin m_hand.push_back(shoe); m_busy = 2; end
        end
    endfunction

    function automatic logic [20:0] model_vec();
        int a[3];
        for (int i = 0; i < 3; i++) a[i] = (i < m_hand.size()) ? m_hand[i] : 0;
        return pack(4'(a[0]), 4'(a[1]), 4'(a[2]), 2'(m_hand.size()), 4'(m_score), m_ack, m_nack);
    endfunction

    // Assert reset partway through the high phase; outputs must clear at once.
    task automatic mid_reset(input string name);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check(name, dut_vec(), 21'd0);
        req = 1'b0; clr = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        // Vector i is driven during cycle i after reset release (shoe = i%13+1).
        idle(6, 0, 0, 0, 0, 0);                         // 0-5
        v(1, 0, 7, 0, 0, 1, 0, 0, 0);                   // 6  deal shoe=7
        v(1, 0, 7, 0, 0, 1, 7, 0, 0);                   // 7  req ignored in LOAD
        v(0, 0, 7, 0, 0, 1, 7, 1, 0);                   // 8  ack
        idle(11, 7, 0, 0, 1, 7);                        // 9-19
        v(1, 0, 7, 8, 0, 2, 7, 0, 0);                   // 20 deal 8
        v(0, 0, 7, 8, 0, 2, 5, 0, 0);                   // 21 score 15 mod 10
        v(0, 0, 7, 8, 0, 2, 5, 1, 0);                   // 22
        idle(2, 7, 8, 0, 2, 5);                         // 23-24
        v(1, 0, 7, 8, 13, 3, 5, 0, 0);                  // 25 deal K, hand full
        v(0, 0, 7, 8, 13, 3, 5, 0, 0);                  // 26
        v(0, 0, 7, 8, 13, 3, 5, 1, 0);                  // 27
        v(1, 0, 7, 8, 13, 3, 5, 0, 1);                  // 28 fourth request -> nack
        v(0, 0, 7, 8, 13, 3, 5, 0, 0);                  // 29
        v(0, 1, 0, 0, 0, 0, 0, 0, 0);                   // 30 clear
        idle(7, 0, 0, 0, 0, 0);                         // 31-37
        v(1, 0, 13, 0, 0, 1, 0, 0, 0);                  // 38 shoe=13
        v(0, 0, 13, 0, 0, 1, 0, 0, 0);                  // 39
        v(0, 0, 13, 0, 0, 1, 0, 1, 0);                  // 40
        v(0, 0, 13, 0, 0, 1, 0, 0, 0);                  // 41 one idle cycle
        v(1, 0, 13, 4, 0, 2, 0, 0, 0);                  // 42 shoe wrapped -> 4
        v(0, 0, 13, 4, 0, 2, 4, 0, 0);                  // 43
        v(0, 0, 13, 4, 0, 2, 4, 1, 0);                  // 44
        v(1, 1, 0, 0, 0, 0, 0, 0, 0);                   // 45 clear beats deal
        idle(1, 0, 0, 0, 0, 0);                         // 46
        v(1, 0, 9, 0, 0, 1, 0, 0, 0);                   // 47
        v(0, 0, 9, 0, 0, 1, 9, 0, 0);                   // 48
        v(0, 1, 0, 0, 0, 0, 0, 0, 0);                   // 49 clear during SCORE
        idle(1, 0, 0, 0, 0, 0);                         // 50 no ack
        v(1, 0, 13, 0, 0, 1, 0, 0, 0);                  // 51
        v(0, 1, 0, 0, 0, 0, 0, 0, 0);                   // 52 clear during LOAD
        idle(2, 0, 0, 0, 0, 0);                         // 53-54
        v(1, 0, 4, 0, 0, 1, 0, 0, 0);                   // 55 held request
        v(1, 0, 4, 0, 0, 1, 4, 0, 0);                   // 56
        v(1, 0, 4, 0, 0, 1, 4, 1, 0);                   // 57
        v(1, 0, 4, 7, 0, 2, 4, 0, 0);                   // 58 re-deal on IDLE
        v(1, 0, 4, 7, 0, 2, 1, 0, 0);                   // 59
        v(1, 0, 4, 7, 0, 2, 1, 1, 0);                   // 60
        v(1, 0, 4, 7, 10, 3, 1, 0, 0);                  // 61 ten scores 0
        v(1, 0, 4, 7, 10, 3, 1, 0, 0);                  // 62
        v(1, 0, 4, 7, 10, 3, 1, 1, 0);                  // 63
        v(1, 0, 4, 7, 10, 3, 1, 0, 1);                  // 64 full -> nack
        v(1, 0, 4, 7, 10, 3, 1, 0, 1);                  // 65 nack again
        v(0, 1, 0, 0, 0, 0, 0, 0, 0);                   // 66 clear

        rst = 1'b1; req = 1'b0; clr = 1'b0;
        model_reset();
        #3 check("reset_hold", dut_vec(), 21'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            req = tbl[i].req; clr = tbl[i].clr;
            @(negedge clk);
            check($sformatf("vec%0d", i), dut_vec(),
                  pack(tbl[i].c0, tbl[i].c1, tbl[i].c2, tbl[i].num, tbl[i].sc,
                       tbl[i].ack, tbl[i].nack));
        end

        // Reset while a deal sits in LOAD.
        req = 1'b1; clr = 1'b0;
        mid_reset("reset_in_load");

        // Randomized run against the model, with one mid-run reset.
        for (int k = 0; k < 600; k++) begin
            if (k == 300) begin
                req = 1'b1; clr = 1'b0;
                mid_reset("reset_random");
            end
            req = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 23) == 0);
            model_step(req, clr);
            @(negedge clk);
            check($sformatf("rand%0d", k), dut_vec(), model_vec());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
